// File: rtl/serial_program_loader.sv
// Boot loader: receives a length-prefixed program over an 8N1 UART line and writes it
// word-by-word into instruction memory while holding the core stalled.
module serial_program_loader #(
   parameter int CLOCK_HZ          = 50000000,
   parameter int BAUD              = 115200,
   parameter int ADDR_WIDTH        = 14,
   parameter int INSTRUCTION_WIDTH = 16
) (
   input  logic                         fast_clock,
   input  logic                         reset,
   input  logic                         rx,
   input  logic                         start,
   output logic                         mem_write_enable,
   output logic [ADDR_WIDTH-1:0]        mem_address,
   output logic [INSTRUCTION_WIDTH-1:0] mem_data,
   output logic                         hold_cpu,
   output logic                         done,
   output logic                         error,
   output logic [ADDR_WIDTH:0]          words_loaded
);

   localparam int CLKS_PER_BIT = CLOCK_HZ / BAUD;
   localparam int TIMER_W      = $clog2(CLKS_PER_BIT);
   localparam logic [TIMER_W-1:0] HALF_LAST = TIMER_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [TIMER_W-1:0] BIT_LAST  = TIMER_W'(CLKS_PER_BIT - 1);
   localparam logic [31:0]        MAX_WORDS = 32'd1 << ADDR_WIDTH;

   typedef enum logic [1:0] {
      R_IDLE,
      R_START,
      R_DATA,
      R_STOP
   } rx_state_t;

   typedef enum logic [2:0] {
      L_IDLE,
      L_LEN_HI,
      L_LEN_LO,
      L_WORD_HI,
      L_WORD_LO,
      L_WRITE,
      L_DONE,
      L_ERROR
   } ld_state_t;

   logic               rx_meta;
   logic               rx_sync;
   logic               rx_prev;

   rx_state_t          rx_state;
   logic [TIMER_W-1:0] bit_timer;
   logic [2:0]         bit_idx;
   logic [7:0]         rx_byte;
   logic               byte_valid;
   logic               frame_err;

   ld_state_t          ld_state;
   logic [15:0]        word_count;
   logic [7:0]         hi_byte;
   logic [15:0]        len_received;
   logic [ADDR_WIDTH:0] loaded_next;
   logic               last_word;
   logic               len_too_big;

   // NOTE: the synchronizer resets to the idle-high line level so that leaving reset
   // never looks like a falling start edge. All state uses non-blocking assignments.
   always_ff @(posedge fast_clock or negedge reset) begin
      if (!reset) begin
         rx_meta <= 1'b1;
         rx_sync <= 1'b1;
         rx_prev <= 1'b1;
      end else begin
         rx_meta <= rx;
         rx_sync <= rx_meta;
         rx_prev <= rx_sync;
      end
   end

   // Receiver: byte_valid and frame_err are single-cycle pulses; rx_byte holds until the next frame.
   always_ff @(posedge fast_clock or negedge reset) begin
      if (!reset) begin
         rx_state   <= R_IDLE;
         bit_timer  <= '0;
         bit_idx    <= '0;
         rx_byte    <= '0;
         byte_valid <= 1'b0;
         frame_err  <= 1'b0;
      end else begin
         byte_valid <= 1'b0;
         frame_err  <= 1'b0;
         case (rx_state)
            R_IDLE: begin
               if (rx_prev && !rx_sync) begin
                  rx_state  <= R_START;
                  bit_timer <= '0;
               end
            end
            R_START: begin
               if (bit_timer == HALF_LAST) begin
                  bit_timer <= '0;
                  bit_idx   <= '0;
                  rx_state  <= rx_sync ? R_IDLE : R_DATA;
               end else begin
                  bit_timer <= bit_timer + 1'b1;
               end
            end
            R_DATA: begin
               if (bit_timer == BIT_LAST) begin
                  bit_timer <= '0;
                  rx_byte   <= {rx_sync, rx_byte[7:1]};
                  if (bit_idx == 3'd7) begin
                     rx_state <= R_STOP;
                  end else begin
                     bit_idx <= bit_idx + 1'b1;
                  end
               end else begin
                  bit_timer <= bit_timer + 1'b1;
               end
            end
            R_STOP: begin
               if (bit_timer == BIT_LAST) begin
                  bit_timer <= '0;
                  rx_state  <= R_IDLE;
                  if (rx_sync) begin
                     byte_valid <= 1'b1;
                  end else begin
                     frame_err <= 1'b1;
                  end
               end else begin
                  bit_timer <= bit_timer + 1'b1;
               end
            end
            default: rx_state <= R_IDLE;
         endcase
      end
   end

   assign len_received = {word_count[15:8], rx_byte};
   assign len_too_big  = 32'(len_received) > MAX_WORDS;
   assign loaded_next  = words_loaded + 1'b1;
   assign last_word    = 32'(loaded_next) == 32'(word_count);

   always_ff @(posedge fast_clock or negedge reset) begin
      if (!reset) begin
         ld_state         <= L_IDLE;
         word_count       <= '0;
         hi_byte          <= '0;
         mem_write_enable <= 1'b0;
         mem_address      <= '0;
         mem_data         <= '0;
         hold_cpu         <= 1'b0;
         done             <= 1'b0;
         error            <= 1'b0;
         words_loaded     <= '0;
      end else begin
         case (ld_state)
            L_IDLE, L_DONE: begin
               if (start) begin
                  ld_state     <= L_LEN_HI;
                  hold_cpu     <= 1'b1;
                  done         <= 1'b0;
                  mem_address  <= '0;
                  words_loaded <= '0;
               end
            end
            L_LEN_HI: begin
               if (frame_err) begin
                  ld_state <= L_ERROR;
                  error    <= 1'b1;
               end else if (byte_valid) begin
                  word_count[15:8] <= rx_byte;
                  ld_state         <= L_LEN_LO;
               end
            end
            L_LEN_LO: begin
               if (frame_err) begin
                  ld_state <= L_ERROR;
                  error    <= 1'b1;
               end else if (byte_valid) begin
                  word_count[7:0] <= rx_byte;
                  if (len_received == 16'd0) begin
                     ld_state <= L_DONE;
                     hold_cpu <= 1'b0;
                     done     <= 1'b1;
                  end else if (len_too_big) begin
                     ld_state <= L_ERROR;
                     error    <= 1'b1;
                  end else begin
                     ld_state <= L_WORD_HI;
                  end
               end
            end
            L_WORD_HI: begin
               if (frame_err) begin
                  ld_state <= L_ERROR;
                  error    <= 1'b1;
               end else if (byte_valid) begin
                  hi_byte  <= rx_byte;
                  ld_state <= L_WORD_LO;
               end
            end
            L_WORD_LO: begin
               if (frame_err) begin
                  ld_state <= L_ERROR;
                  error    <= 1'b1;
               end else if (byte_valid) begin
                  mem_data         <= INSTRUCTION_WIDTH'({hi_byte, rx_byte});
                  mem_write_enable <= 1'b1;
                  ld_state         <= L_WRITE;
               end
            end
            L_WRITE: begin
               // The strobe is high for exactly this one state; advance to the next slot.
               mem_write_enable <= 1'b0;
               mem_address      <= mem_address + 1'b1;
               words_loaded     <= loaded_next;
               if (last_word) begin
                  ld_state <= L_DONE;
                  hold_cpu <= 1'b0;
                  done     <= 1'b1;
               end else begin
                  ld_state <= L_WORD_HI;
               end
            end
            L_ERROR: begin
               hold_cpu <= 1'b1;
               error    <= 1'b1;
            end
            default: ld_state <= L_ERROR;
         endcase
      end
   end

endmodule
